sdram_frame_reader: RTL and testbench

SDRAM_FRAME_READER -- requirements
Module: sdram_frame_reader

---
 rtl/sdram_pkg.sv | 17 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/sdram_frame_reader.sv | 151 +++++++++++++++
 tb/tb_sdram_frame_reader.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - SDRAM controller command codes and frame reader state encoding
package sdram_pkg;

    localparam logic [1:0] SDRAM_CMD_IDLE  = 2'd0;
    localparam logic [1:0] SDRAM_CMD_WRITE = 2'd1;
    localparam logic [1:0] SDRAM_CMD_READ  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_REQ,
        ST_BURST,
        ST_NEXT,
        ST_DONE
    } frame_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word fall-through FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A paired push/pop is always honoured, so full and empty never block the pair.
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && (!empty || push);
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/sdram_frame_reader.sv
// rtl/sdram_frame_reader.sv - burst-reads one frame from SDRAM into a pixel FIFO
// Optional underflow detection: SDRAM_FRAME_READER_UNDERFLOW_EN
module sdram_frame_reader
    import sdram_pkg::*;
#(
    parameter int USER_ADDRESS_WIDTH = 22,
    parameter int DATA_WIDTH         = 16,
    parameter int READ_BURST_LENGTH  = 4,
    parameter int FRAME_WORDS        = 8192,
    parameter int BASE_ADDRESS       = 0,
    parameter int FIFO_DEPTH         = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_start,
    output logic [1:0]                    ctrl_command,
    output logic [USER_ADDRESS_WIDTH-1:0] ctrl_address,
    input  logic [DATA_WIDTH-1:0]         ctrl_data_read,
    input  logic                          ctrl_data_read_valid,
    output logic [DATA_WIDTH-1:0]         pix_data,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          underflow
);

    localparam int AW     = USER_ADDRESS_WIDTH;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WL_W   = $clog2(FRAME_WORDS + 1);
    localparam int BEAT_W = 4;

    frame_state_t     state, state_n;
    logic [AW-1:0]    addr, addr_n;
    logic [WL_W-1:0]  words_left, words_left_n;
    logic [BEAT_W-1:0] beat, beat_n;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             room;
    logic             start_ok;

    assign start_ok = (state == ST_IDLE) && frame_start && !ctrl_data_read_valid;
    // Only request a burst when the whole burst is guaranteed a slot in the FIFO.
    assign room     = !fifo_full &&
                      ((CNT_W'(FIFO_DEPTH) - fifo_count) >= CNT_W'(READ_BURST_LENGTH));
    assign push     = ctrl_data_read_valid && ((state == ST_REQ) || (state == ST_BURST));
    assign pop      = pix_valid && pix_ready;

    assign ctrl_command = (state == ST_REQ) ? SDRAM_CMD_READ : SDRAM_CMD_IDLE;
    assign ctrl_address = addr;
    assign busy         = (state != ST_IDLE);
    assign frame_done   = (state == ST_DONE);
    assign pix_valid    = !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            addr       <= AW'(BASE_ADDRESS);
            words_left <= '0;
            beat       <= '0;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            words_left <= words_left_n;
            beat       <= beat_n;
        end
    end

    always_comb begin
        state_n      = state;
        addr_n       = addr;
        words_left_n = words_left;
        beat_n       = beat;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    addr_n       = AW'(BASE_ADDRESS);
                    words_left_n = WL_W'(FRAME_WORDS);
                    state_n      = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (room) begin
                    state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ctrl_data_read_valid) begin
                    beat_n  = BEAT_W'(1);
                    state_n = (READ_BURST_LENGTH == 1) ? ST_NEXT : ST_BURST;
                end
            end
            ST_BURST: begin
                if (ctrl_data_read_valid) begin
                    beat_n = beat + 1'b1;
                    if (beat == BEAT_W'(READ_BURST_LENGTH - 1)) begin
                        state_n = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                addr_n       = addr + AW'(READ_BURST_LENGTH);
                words_left_n = words_left - WL_W'(READ_BURST_LENGTH);
                state_n      = (words_left == WL_W'(READ_BURST_LENGTH)) ? ST_DONE : ST_CHECK;
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .data_in  (ctrl_data_read),
        .pop      (pop),
        .data_out (pix_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

`ifdef SDRAM_FRAME_READER_UNDERFLOW_EN
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underflow_q <= 1'b0;
        end else if (start_ok) begin
            underflow_q <= 1'b0;
        end else if (busy && pix_ready && fifo_empty) begin
            underflow_q <= 1'b1;
        end
    end

    assign underflow = underflow_q;
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_frame_reader.sv
// tb/tb_sdram_frame_reader.sv - randomized scoreboard bench for sdram_frame_reader
module tb_sdram_frame_reader;
    import sdram_pkg::*;

    localparam int AW     = 22;
    localparam int DW     = 16;
    localparam int RBL    = 4;
    localparam int FW     = 16;
    localparam int BASE   = 32'h100;
    localparam int BASE_W = (1 << 22) - 8;
    localparam int DEPTH  = 8;
    localparam int LAT    = 3;
`ifdef SDRAM_FRAME_READER_UNDERFLOW_EN
    localparam logic EXP_UF = 1'b1;
`else
    localparam logic EXP_UF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic [1:0]    ctrl_command;
    logic [AW-1:0] ctrl_address;
    logic [DW-1:0] ctrl_data_read = '0;
    logic          ctrl_data_read_valid = 1'b0;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic          busy, frame_done, underflow;

    logic          fs_w = 1'b0;
    logic [1:0]    cmd_w;
    logic [AW-1:0] addr_w;
    logic [DW-1:0] rd_w = '0;
    logic          rdv_w = 1'b0;
    logic [DW-1:0] pix_data_w;
    logic          pix_valid_w;
    logic          pix_ready_w = 1'b1;
    logic          busy_w, done_w, underflow_w;

    int vectors = 0;
    int errors  = 0;

    sdram_frame_reader #(
        .USER_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_BURST_LENGTH(RBL),
        .FRAME_WORDS(FW), .BASE_ADDRESS(BASE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .ctrl_command(ctrl_command), .ctrl_address(ctrl_address),
        .ctrl_data_read(ctrl_data_read), .ctrl_data_read_valid(ctrl_data_read_valid),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .busy(busy), .frame_done(frame_done), .underflow(underflow)
    );

    sdram_frame_reader #(
        .USER_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_BURST_LENGTH(RBL),
        .FRAME_WORDS(FW), .BASE_ADDRESS(BASE_W), .FIFO_DEPTH(DEPTH)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_w),
        .ctrl_command(cmd_w), .ctrl_address(addr_w),
        .ctrl_data_read(rd_w), .ctrl_data_read_valid(rdv_w),
        .pix_data(pix_data_w), .pix_valid(pix_valid_w), .pix_ready(pix_ready_w),
        .busy(busy_w), .frame_done(done_w), .underflow(underflow_w)
    );

    // Controller models: read command seen in cycle C gives beats in cycles C+3..C+3+RBL-1.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic [AW-1:0] addr_q[$];
    logic [AW-1:0] addr_w_q[$];
    int lat = -1, cur_beat = -1, lat_w = -1;
    int done_cnt = 0, done_w_cnt = 0;
    bit bad_cmd = 1'b0;

    always @(posedge clk) begin
        #1;
        if (lat >= 0) lat++;
        if (lat >= LAT + RBL) lat = -1;
        if (lat < 0 && ctrl_command == SDRAM_CMD_READ) begin
            lat = 0;
            addr_q.push_back(ctrl_address);
        end
        if (lat >= LAT) begin
            ctrl_data_read_valid = 1'b1;
            ctrl_data_read = DW'($urandom);
            exp_q.push_back(ctrl_data_read);
            cur_beat = lat - LAT;
        end else begin
            ctrl_data_read_valid = 1'b0;
            cur_beat = -1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (lat_w >= 0) lat_w++;
        if (lat_w >= LAT + RBL) lat_w = -1;
        if (lat_w < 0 && cmd_w == SDRAM_CMD_READ) begin
            lat_w = 0;
            addr_w_q.push_back(addr_w);
        end
        rdv_w = (lat_w >= LAT);
        rd_w  = DW'($urandom);
    end

    always @(negedge clk) begin
        if (rst_n && pix_valid && pix_ready) got_q.push_back(pix_data);
        if (frame_done) done_cnt++;
        if (done_w) done_w_cnt++;
        if (ctrl_command != SDRAM_CMD_IDLE && ctrl_command != SDRAM_CMD_READ) bad_cmd = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_frame();
        @(posedge clk); #2 frame_start = 1'b1;
        @(posedge clk); #2 frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic clear_sb();
        exp_q.delete(); got_q.delete(); addr_q.delete();
        done_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        vectors++; if (ctrl_command !== SDRAM_CMD_IDLE) begin errors++; $display("FAIL reset_cmd: got %0d expected 0", ctrl_command); end
        vectors++; if (ctrl_address !== AW'(BASE)) begin errors++; $display("FAIL reset_addr: got %0h expected %0h", ctrl_address, BASE); end
        vectors++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid: got %b expected 0", pix_valid); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", frame_done); end
        vectors++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
        rst_n = 1'b1;
        tick(2);
    endtask

    // Reference: the frame is FW/RBL bursts at BASE+k*RBL, words delivered in arrival order.
    task automatic check_frames(input string tag, input int frames, input int base);
        vectors++; if (addr_q.size() != frames * FW / RBL) begin errors++; $display("FAIL %s_burst_count: got %0d expected %0d", tag, addr_q.size(), frames * FW / RBL); end
        for (int k = 0; k < addr_q.size(); k++) begin
            logic [AW-1:0] ea;
            ea = AW'((base + RBL * (k % (FW / RBL))) % (1 << AW));
            vectors++; if (addr_q[k] !== ea) begin errors++; $display("FAIL %s_addr[%0d]: got %0h expected %0h", tag, k, addr_q[k], ea); end
        end
        vectors++; if (got_q.size() != frames * FW) begin errors++; $display("FAIL %s_word_count: got %0d expected %0d", tag, got_q.size(), frames * FW); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_word[%0d]: got %0h expected %0h", tag, i, got_q[i], exp_q[i]); end
        end
        vectors++; if (done_cnt != frames) begin errors++; $display("FAIL %s_done_pulses: got %0d expected %0d", tag, done_cnt, frames); end
    endtask

    task automatic test_single_frame();
        bit ok;
        clear_sb();
        pix_ready = 1'b1;
        start_frame();
        wait_idle(400, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL single_timeout: got busy expected idle"); end
        tick(5);
        check_frames("single", 1, BASE);
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_sb();
        pix_ready = 1'b0;
        start_frame();
        tick(60);
        vectors++; if (addr_q.size() != 2) begin errors++; $display("FAIL bp_bursts_full: got %0d expected 2", addr_q.size()); end
        vectors++; if (dut.u_fifo.count !== 4'(DEPTH)) begin errors++; $display("FAIL bp_fifo_count: got %0d expected %0d", dut.u_fifo.count, DEPTH); end
        vectors++; if (ctrl_command !== SDRAM_CMD_IDLE) begin errors++; $display("FAIL bp_cmd_wait: got %0d expected 0", ctrl_command); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b expected 1", busy); end
        for (int p = 0; p < 4; p++) begin
            pix_ready = 1'b1;
            tick(1);
            pix_ready = 1'b0;
            tick(20);
            vectors++; if (addr_q.size() != ((p == 3) ? 3 : 2)) begin errors++; $display("FAIL bp_bursts_after_%0d_pops: got %0d expected %0d", p + 1, addr_q.size(), (p == 3) ? 3 : 2); end
        end
        pix_ready = 1'b1;
        wait_idle(400, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL bp_timeout: got busy expected idle"); end
        tick(5);
        check_frames("bp", 1, BASE);
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_sb();
        for (int f = 0; f < 2; f++) begin
            start_frame();
            ok = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                @(posedge clk); #2;
                pix_ready = 1'($urandom_range(0, 1));
                if (!busy) begin
                    ok = 1'b1;
                    break;
                end
            end
            vectors++; if (!ok) begin errors++; $display("FAIL b2b_timeout_%0d: got busy expected idle", f); end
        end
        pix_ready = 1'b1;
        tick(10);
        check_frames("b2b", 2, BASE);
    endtask

    task automatic test_busy_start();
        bit ok;
        clear_sb();
        pix_ready = 1'b1;
        start_frame();
        tick(10);
        start_frame();
        wait_idle(400, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL busy_start_timeout: got busy expected idle"); end
        tick(20);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_restart: got busy %b expected 0", busy); end
        check_frames("busy_start", 1, BASE);
    endtask

    task automatic test_reset_mid_burst();
        int n_got;
        bit found;
        clear_sb();
        pix_ready = 1'b1;
        start_frame();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ctrl_data_read_valid && cur_beat == 2) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        vectors++; if (!found) begin errors++; $display("FAIL rst_mid_beat2_seen: got none expected beat 2"); end
        rst_n = 1'b0;
        tick(1);
        vectors++; if (ctrl_command !== SDRAM_CMD_IDLE) begin errors++; $display("FAIL rst_mid_cmd: got %0d expected 0", ctrl_command); end
        vectors++; if (ctrl_address !== AW'(BASE)) begin errors++; $display("FAIL rst_mid_addr: got %0h expected %0h", ctrl_address, BASE); end
        vectors++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_pix_valid: got %b expected 0", pix_valid); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        vectors++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b expected 0", frame_done); end
        vectors++; if (underflow !== 1'b0) begin errors++; $display("FAIL rst_mid_underflow: got %b expected 0", underflow); end
        // Beat 3 still arrives; a frame_start coinciding with it must be ignored.
        rst_n = 1'b1;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_start_during_beat: got busy %b expected 0", busy); end
        n_got = got_q.size();
        tick(15);
        vectors++; if (got_q.size() != n_got || pix_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale_beats: got %0d extra words expected 0", got_q.size() - n_got); end
        clear_sb();
    endtask

    task automatic test_wrap();
        bit ok;
        addr_w_q.delete();
        done_w_cnt = 0;
        @(posedge clk); #2 fs_w = 1'b1;
        @(posedge clk); #2 fs_w = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!busy_w) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        vectors++; if (!ok) begin errors++; $display("FAIL wrap_timeout: got busy expected idle"); end
        tick(5);
        vectors++; if (addr_w_q.size() != FW / RBL) begin errors++; $display("FAIL wrap_burst_count: got %0d expected %0d", addr_w_q.size(), FW / RBL); end
        for (int k = 0; k < addr_w_q.size(); k++) begin
            logic [AW-1:0] ea;
            ea = AW'((BASE_W + RBL * k) % (1 << AW));
            vectors++; if (addr_w_q[k] !== ea) begin errors++; $display("FAIL wrap_addr[%0d]: got %0h expected %0h", k, addr_w_q[k], ea); end
        end
        vectors++; if (done_w_cnt != 1) begin errors++; $display("FAIL wrap_done_pulses: got %0d expected 1", done_w_cnt); end
    endtask

    task automatic test_underflow();
        bit ok;
        clear_sb();
        pix_ready = 1'b1;
        start_frame();
        wait_idle(400, ok);
        vectors++; if (underflow !== EXP_UF) begin errors++; $display("FAIL uf_set: got %b expected %b", underflow, EXP_UF); end
        tick(10);
        vectors++; if (underflow !== EXP_UF) begin errors++; $display("FAIL uf_sticky: got %b expected %b", underflow, EXP_UF); end
        pix_ready = 1'b0;
        start_frame();
        tick(3);
        vectors++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_cleared_by_start: got %b expected 0", underflow); end
        pix_ready = 1'b1;
        wait_idle(400, ok);
        vectors++; if (!ok) begin errors++; $display("FAIL uf_timeout: got busy expected idle"); end
        tick(5);
        check_frames("uf", 2, BASE);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_busy_start();
        test_reset_mid_burst();
        test_wrap();
        test_underflow();
        vectors++; if (bad_cmd) begin errors++; $display("FAIL cmd_legal: got command 1 or 3 expected only 0 or 2"); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
